// File: rtl/wb_regfile.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_regfile : MEM/WB write-back, 32x32 register file with write-first     |
// |              bypass read ports and retire counter; WB_TRACE_EN adds a    |
// |              registered write trace port.            Revision: 1.0       |
// +------------------------------------------------------------------------+
module wb_regfile #(
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 5,
  parameter  int NREG     = 32,
  parameter  int CNT_W    = 32,
  localparam int BUNDLE_W = 2 + 2*DATA_W + ADDR_W
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [BUNDLE_W-1:0] mem_wb_in,
  input  logic                mem_wb_valid,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic [ADDR_W-1:0]   rt_addr,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic                wb_en,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic [CNT_W-1:0]    retired
`ifdef WB_TRACE_EN
  ,
  output logic                trace_valid,
  output logic [ADDR_W-1:0]   trace_addr,
  output logic [DATA_W-1:0]   trace_data
`endif
);

  generate
    if (NREG != (1 << ADDR_W)) begin : g_bad_nreg
      $error("wb_regfile: NREG must equal 2**ADDR_W");
    end
  endgenerate

  logic              reg_write;
  logic              mem_to_reg;
  logic [DATA_W-1:0] dm_out;
  logic [DATA_W-1:0] alu_out;
  logic [ADDR_W-1:0] dest;

  assign reg_write  = mem_wb_in[BUNDLE_W-1];
  assign mem_to_reg = mem_wb_in[BUNDLE_W-2];
  assign dm_out     = mem_wb_in[BUNDLE_W-3 -: DATA_W];
  assign alu_out    = mem_wb_in[ADDR_W +: DATA_W];
  assign dest       = mem_wb_in[ADDR_W-1:0];

  assign wb_en   = mem_wb_valid & reg_write & (dest != '0);
  assign wb_addr = dest;
  assign wb_data = mem_to_reg ? dm_out : alu_out;

  logic [DATA_W-1:0] regs [NREG];

  // Entry 0 is never written because wb_en excludes dest 0; reads mask it anyway.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (wb_en && (rs_addr == wb_addr)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (wb_en && (rt_addr == wb_addr)) begin
      rt_data = wb_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (mem_wb_valid) begin
      retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= wb_en;
      if (wb_en) begin
        trace_addr <= wb_addr;
        trace_data <= wb_data;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// tb_wb_regfile : vector table, randomized model comparison and reset/wrap/trace
// sequences for wb_regfile.
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [70:0] mem_wb_in;
  logic        mem_wb_valid;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] retired;
  logic [31:0] rs_data4, rt_data4, wb_data4;
  logic        wb_en4;
  logic [4:0]  wb_addr4;
  logic [3:0]  retired4;
`ifdef WB_TRACE_EN
  logic        trace_valid, trace_valid4;
  logic [4:0]  trace_addr, trace_addr4;
  logic [31:0] trace_data, trace_data4;
`endif

  wb_regfile dut (
    .clock(clock), .rst_n(rst_n), .mem_wb_in(mem_wb_in), .mem_wb_valid(mem_wb_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
`ifdef WB_TRACE_EN
    , .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data)
`endif
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clock(clock), .rst_n(rst_n), .mem_wb_in(mem_wb_in), .mem_wb_valid(mem_wb_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data4), .rt_data(rt_data4),
    .wb_en(wb_en4), .wb_addr(wb_addr4), .wb_data(wb_data4), .retired(retired4)
`ifdef WB_TRACE_EN
    , .trace_valid(trace_valid4), .trace_addr(trace_addr4), .trace_data(trace_data4)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1, "watchdog");
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Reference model: architectural register contents and retire count.
  logic [31:0] m_regs [32];
  int unsigned m_ret;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ret = 0;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] dm, input logic [31:0] alu,
                       input logic [4:0] d, input logic [4:0] ra, input logic [4:0] rb);
    mem_wb_valid = v;
    mem_wb_in    = {rw, m2r, dm, alu, d};
    rs_addr      = ra;
    rt_addr      = rb;
  endtask

  // Architectural effect of the bundle currently on the inputs.
  task automatic commit();
    logic        rw, m2r;
    logic [31:0] dm, alu;
    logic [4:0]  d;
    {rw, m2r, dm, alu, d} = mem_wb_in;
    if (mem_wb_valid) begin
      m_ret++;
      if (rw && d != 0) m_regs[d] = m2r ? dm : alu;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic        rw, m2r;
    logic [31:0] dm, alu;
    logic [4:0]  d;
    {rw, m2r, dm, alu, d} = mem_wb_in;
    if (a == 0) return 32'h0;
    if (mem_wb_valid && rw && d != 0 && a == d) return m2r ? dm : alu;
    return m_regs[a];
  endfunction

  typedef struct {
    logic        valid, rw, m2r;
    logic [31:0] dm, alu;
    logic [4:0]  dest, rs, rt;
    logic        exp_en;
    logic [31:0] exp_data, exp_rs, exp_rt, exp_ret;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0BAD0BAD, 32'hDEADBEEF, 5'd8, 5'd8, 5'd0,
               1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h00001111, 5'd3, 5'd8, 5'd3,
               1'b0, 32'h00001111, 32'hDEADBEEF, 32'h0, 32'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'hCAFE0001, 32'h00000001, 5'd9, 5'd9, 5'd9,
               1'b1, 32'hCAFE0001, 32'hCAFE0001, 32'hCAFE0001, 32'd1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h00000077, 5'd0, 5'd0, 5'd9,
               1'b0, 32'h00000077, 32'h0, 32'hCAFE0001, 32'd2};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h00000055, 5'd8, 5'd8, 5'd3,
               1'b0, 32'h00000055, 32'hDEADBEEF, 32'h0, 32'd3};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h12345678, 5'd8, 5'd8, 5'd9,
               1'b1, 32'h12345678, 32'h12345678, 32'hCAFE0001, 32'd4};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd8, 5'd8, 5'd3,
               1'b0, 32'h0, 32'h12345678, 32'h0, 32'd5};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_retired", retired, 32'd0);
    chk("reset_retired4", {28'h0, retired4}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      drive(tbl[i].valid, tbl[i].rw, tbl[i].m2r, tbl[i].dm, tbl[i].alu,
            tbl[i].dest, tbl[i].rs, tbl[i].rt);
      #1;
      chk($sformatf("tbl%0d_wb_en", i), {31'h0, wb_en}, {31'h0, tbl[i].exp_en});
      chk($sformatf("tbl%0d_wb_addr", i), {27'h0, wb_addr}, {27'h0, tbl[i].dest});
      chk($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_rs", i), rs_data, tbl[i].exp_rs);
      chk($sformatf("tbl%0d_rt", i), rt_data, tbl[i].exp_rt);
      chk($sformatf("tbl%0d_retired", i), retired, tbl[i].exp_ret);
      @(posedge clock);
      #1;
      commit();
    end
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 8, 9);
    #1;
    chk("tbl_end_retired", retired, 32'd5);
    chk("tbl_end_rs8", rs_data, 32'h12345678);
    chk("tbl_end_rt9", rt_data, 32'hCAFE0001);

    for (int n = 0; n < 400; n++) begin
      logic        v, rw, m2r;
      logic [31:0] dm, alu;
      logic [4:0]  d, ra, rb;
      @(negedge clock);
      v   = ($urandom_range(0, 3) != 0);
      rw  = $urandom_range(0, 1) == 1;
      m2r = $urandom_range(0, 1) == 1;
      dm  = $urandom;
      alu = $urandom;
      d   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ra  = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
      rb  = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
      drive(v, rw, m2r, dm, alu, d, ra, rb);
      #1;
      chk("rnd_wb_en", {31'h0, wb_en}, {31'h0, (v && rw && d != 0)});
      chk("rnd_wb_addr", {27'h0, wb_addr}, {27'h0, d});
      chk("rnd_wb_data", wb_data, m2r ? dm : alu);
      chk("rnd_rs", rs_data, exp_read(ra));
      chk("rnd_rt", rt_data, exp_read(rb));
      chk("rnd_retired", retired, m_ret);
      chk("rnd_retired4", {28'h0, retired4}, m_ret % 16);
      @(posedge clock);
      #1;
      commit();
    end

    // Asynchronous reset mid-cycle clears the array immediately.
    @(negedge clock);
    drive(1, 1, 0, 0, 32'h00001234, 5, 5, 5);
    @(posedge clock);
    #1;
    commit();
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    chk("pre_reset_rs5", rs_data, 32'h00001234);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_rs5", rs_data, 32'h0);
    chk("async_reset_retired", retired, 32'd0);

    // Bundle held through reset is processed on the first edge after release.
    drive(1, 1, 0, 0, 32'h0000ABCD, 6, 6, 0);
    @(posedge clock);
    @(negedge clock);
    chk("in_reset_retired", retired, 32'd0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    commit();
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 6, 0);
    #1;
    chk("release_rs6", rs_data, 32'h0000ABCD);
    chk("release_retired", retired, 32'd1);

    // Counter wrap on the 4-bit instance.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      drive(1, 0, 0, 0, i, 3, 0, 0);
      @(posedge clock);
      #1;
      commit();
    end
    @(negedge clock);
    drive(0, 1, 0, 0, 32'h99, 3, 3, 0);
    #1;
    chk("wrap_retired4", {28'h0, retired4}, 32'd1);
    chk("wrap_retired", retired, 32'd17);
    chk("bubble_rs3", rs_data, 32'h0);
    @(posedge clock);
    #1;
    chk("bubble_retired", retired, 32'd17);

`ifdef WB_TRACE_EN
    @(negedge clock);
    drive(1, 1, 0, 0, 32'h55, 4, 0, 0);
    @(posedge clock);
    #1;
    chk("trace_valid_hi", {31'h0, trace_valid}, 32'd1);
    chk("trace_addr", {27'h0, trace_addr}, 32'd4);
    chk("trace_data", trace_data, 32'h55);
    @(negedge clock);
    drive(0, 1, 0, 0, 32'h66, 7, 0, 0);
    @(posedge clock);
    #1;
    chk("trace_valid_lo", {31'h0, trace_valid}, 32'd0);
    chk("trace_addr_hold", {27'h0, trace_addr}, 32'd4);
    chk("trace_data_hold", trace_data, 32'h55);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the pipeline: consumes the 71-bit MEM/WB bundle, selects the write-back data, and commits it to a 32x32 general register file.
- Provides the two ID-stage read ports with write-first bypass, so an ID read in the same cycle as a WB write sees the new value.
- Counts retired bundles for the bench and debug.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers; must equal 2**ADDR_W.
- CNT_W, 32, retire counter width.
- BUNDLE_W, 2+2*DATA_W+ADDR_W (71), MEM/WB bundle width; derived, do not override.

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_wb_in  in  BUNDLE_W  MEM/WB bundle. Field layout, MSB first:
  - [70] RegWrite
  - [69] MemtoReg
  - [68:37] dm_out
  - [36:5] alu_out
  - [4:0] dest register
- mem_wb_valid  in  1  1 = bundle is a real instruction; 0 = bubble.
- rs_addr  in  ADDR_W  read port A address.
- rt_addr  in  ADDR_W  read port B address.
- rs_data  out  DATA_W  read port A data (combinational).
- rt_data  out  DATA_W  read port B data (combinational).
- wb_en  out  1  combinational: mem_wb_valid & RegWrite & (dest != 0).
- wb_addr  out  ADDR_W  combinational: dest field.
- wb_data  out  DATA_W  combinational: MemtoReg ? dm_out : alu_out.
- retired  out  CNT_W  registered count of valid bundles.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - All NREG registers are cleared to 0.
  - retired is cleared to 0.
  - Combinational outputs follow their inputs; reads return 0 unless bypassed.
- Write:
  - On the rising clock edge with wb_en=1, reg[wb_addr] <= wb_data.
  - One write per cycle; the value is visible in the array from the next cycle.
- Register 0:
  - Hardwired zero; never written.
  - Reads of address 0 return 0 regardless of bypass.
  - A bundle with dest=0 and RegWrite=1 still counts as retired.
- Read and bypass:
  - rs_data = (rs_addr==0) ? 0 : (wb_en && rs_addr==wb_addr) ? wb_data : reg[rs_addr].
  - rt_data uses the same rule with rt_addr.
  - Both ports may bypass in the same cycle (rs==rt==wb_addr).
- Bubble (mem_wb_valid=0):
  - No write, no count; RegWrite in the bundle is ignored.
- Retire counter:
  - retired increments by 1 on every clock edge with mem_wb_valid=1, whatever RegWrite is.
  - Wraps from 2**CNT_W-1 to 0 with no flag.
- Reset deasserted mid-stream: the first clock edge after release processes the current bundle normally.
- Latency:
  - Write-to-read through the array: 1 cycle.
  - Through bypass: 0 cycles.
- No X propagation: wb_data is fully defined for any input bundle.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: adds three ports:
  - trace_valid  out 1
  - trace_addr  out ADDR_W
  - trace_data  out DATA_W
  - On each clock edge with wb_en=1, trace_valid <= 1 and trace_addr/trace_data capture wb_addr/wb_data; otherwise trace_valid <= 0 and addr/data hold.
  - All three reset to 0.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-cycle after writing reg5=0x1234 -> rs_addr=5 reads 0 immediately; retired=0.
- Write/read: valid, RegWrite=1, MemtoReg=0, alu=0xDEADBEEF, dest=8 -> wb_data=0xDEADBEEF; after the edge, rs_addr=8 reads 0xDEADBEEF.
- MemtoReg select and bypass: MemtoReg=1, dm=0xCAFE0001, alu=0x1, dest=9, rs=rt=9 in the same cycle -> rs_data=rt_data=0xCAFE0001 before the edge.
- Reg0 and bubble:
  - dest=0 with RegWrite=1 -> rs_addr=0 reads 0; retired increments.
  - valid=0 with RegWrite=1, dest=3 -> reg3 unchanged; retired unchanged.
- Counter wrap: force CNT_W=4, send 17 valid bundles -> retired=1.
- WB_TRACE_EN: write dest=4 data=0x55 -> trace_valid=1, trace_addr=4, trace_data=0x55 one cycle later; a bubble next cycle -> trace_valid=0.
